// File: rtl/max_pool_2x2_stream.sv
`timescale 1ns/1ps
// max_pool_2x2_stream: streaming 2x2 / stride-2 signed max pooling over a row-major feature map.
// Latency: 1 cycle from an accepted odd-row beat to out_valid; one pooled beat per odd-row input beat.
// Backpressure: even rows are always accepted into the line buffer; odd rows stall while the output register is full and not drained.
// Optional: define MAXPOOL_RELU_EN to clamp negative pooled values to zero (fused ReLU, same latency).
module max_pool_2x2_stream #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ROW_W = 28,
    parameter int ROWS  = 28
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DW-1:0]         in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [(LANES/2)*DW-1:0]     out_data,
    output logic                        out_last,
    output logic                        frame_err
);

    localparam int NB = ROW_W / LANES;
    localparam int OL = LANES / 2;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(NB - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic {
        FILL = 1'b0,
        POOL = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       col_cnt_q;
    logic [RW-1:0]       row_cnt_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                frame_err_q;
    logic [OL*DW-1:0]    out_data_q;
    logic [OL*DW-1:0]    out_data_d;
    logic [LANES*DW-1:0] linebuf_q [NB];
    logic [LANES*DW-1:0] above;
    logic                in_ready_c;
    logic                in_acc;
    logic                row_end;
    logic                frame_end;
    logic                early_last;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Even rows never stall; odd rows need a free (or draining) output register.
    always_comb begin
        in_ready_c = 1'b1;
        if (state_q == POOL) begin
            in_ready_c = !out_valid_q || out_ready;
        end
    end

    assign in_acc     = in_valid && in_ready_c;
    assign row_end    = (col_cnt_q == COL_LAST);
    assign frame_end  = row_end && (row_cnt_q == ROW_LAST);
    // in_last anywhere but the final position aborts the frame and drops the beat.
    assign early_last = in_last && !frame_end;
    assign above      = linebuf_q[col_cnt_q];

    // One 2x2 window per output lane: two pixels from the buffered row above, two from the current beat.
    for (genvar k = 0; k < OL; k++) begin : g_lane
        logic signed [DW-1:0] win_max;
        assign win_max = smax(smax(above[(2*k)*DW +: DW],   above[(2*k+1)*DW +: DW]),
                              smax(in_data[(2*k)*DW +: DW], in_data[(2*k+1)*DW +: DW]));
`ifdef MAXPOOL_RELU_EN
        assign out_data_d[k*DW +: DW] = win_max[DW-1] ? '0 : win_max;
`else
        assign out_data_d[k*DW +: DW] = win_max;
`endif
    end

    // Capture even-row beats so the following odd row can pool against them.
    always_ff @(posedge clk) begin
        if (in_acc && (state_q == FILL) && !early_last) begin
            linebuf_q[col_cnt_q] <= in_data;
        end
    end

    // Row/column tracking, FILL/POOL sequencing, output register and sticky framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (in_acc) begin
                if (early_last) begin
                    frame_err_q <= 1'b1;
                    col_cnt_q   <= '0;
                    row_cnt_q   <= '0;
                    state_q     <= FILL;
                end else begin
                    if (state_q == POOL) begin
                        out_data_q  <= out_data_d;
                        out_last_q  <= frame_end;
                        out_valid_q <= 1'b1;
                    end
                    if (frame_end && !in_last) begin
                        frame_err_q <= 1'b1;
                    end
                    if (row_end) begin
                        col_cnt_q <= '0;
                        row_cnt_q <= (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
                        state_q   <= (state_q == FILL) ? POOL : FILL;
                    end else begin
                        col_cnt_q <= col_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
`timescale 1ns/1ps
// tb_max_pool_2x2_stream: directed and randomized frames against a pixel-grid pooling reference.
// Small instance (8x2 frame) covers handshake, hold, framing errors and reset; default instance covers 28x28.
// Downstream ready is forced high, forced low or randomized per phase.
module tb_max_pool_2x2_stream;

    localparam int L  = 4;
    localparam int OL = 2;
    localparam int SW = 8;
    localparam int SR = 2;
    localparam int SB = SW / L;
    localparam int SN = SB * SR;
    localparam int DWD = 28;
    localparam int DB  = DWD / L;
    localparam int DN  = DB * 28;

    typedef struct {
        logic [31:0] dat;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_in_valid, s_in_ready, s_in_last;
    logic [63:0] s_in_data;
    logic        s_out_valid, s_out_ready, s_out_last, s_frame_err;
    logic [31:0] s_out_data;
    logic        d_in_valid, d_in_ready, d_in_last;
    logic [63:0] d_in_data;
    logic        d_out_valid, d_out_ready, d_out_last, d_frame_err;
    logic [31:0] d_out_data;

    int   rdy_mode;
    logic rnd_bit;
    int   n_checks = 0;
    int   n_errors = 0;
    int   s_pix [SR][SW];
    exp_t s_q[$];
    exp_t d_q[$];
    int   cyc = 0;
    int   d_outs = 0;
    int   d_gaps = 0;
    int   d_prev_cyc = 0;

    assign s_out_ready = (rdy_mode == 0) || ((rdy_mode == 2) && rnd_bit);

    max_pool_2x2_stream #(.DW(16), .LANES(L), .ROW_W(SW), .ROWS(SR)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
        .frame_err(s_frame_err)
    );

    max_pool_2x2_stream u_dflt (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_last(d_out_last),
        .frame_err(d_frame_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (!rst && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                check("s_extra_out", 1, 0);
            end else begin
                e = s_q.pop_front();
                check("s_out_dat", s_out_data, e.dat);
                check("s_out_last", s_out_last, e.last);
            end
        end
    end

    always @(negedge clk) begin : mon_d
        exp_t e;
        if (!rst && d_out_valid && d_out_ready) begin
            if ((d_outs % 7) != 0 && cyc != d_prev_cyc + 1) d_gaps++;
            d_prev_cyc = cyc;
            d_outs++;
            if (d_q.size() == 0) begin
                check("d_extra_out", 1, 0);
            end else begin
                e = d_q.pop_front();
                check("d_out_dat", d_out_data, e.dat);
                check("d_out_last", d_out_last, e.last);
            end
        end
    end

    function automatic logic [63:0] beat_s(input int j);
        logic [63:0] v;
        int r, b;
        r = j / SB;
        b = j % SB;
        for (int k = 0; k < L; k++) v[k*16 +: 16] = 16'(s_pix[r][b*L + k]);
        return v;
    endfunction

    // Reference: each pooled pixel is the max of its 2x2 pixel window; early in_last truncates the frame.
    task automatic model_s(input int early_at);
        int nb;
        nb = (early_at < 0) ? SN : early_at;
        for (int j = 0; j < nb; j++) begin
            int r, b;
            logic [31:0] d;
            r = j / SB;
            b = j % SB;
            if (r % 2 == 1) begin
                for (int k = 0; k < OL; k++) begin
                    int m, c0;
                    c0 = b * L + 2 * k;
                    m = s_pix[r-1][c0];
                    if (s_pix[r-1][c0+1] > m) m = s_pix[r-1][c0+1];
                    if (s_pix[r][c0]     > m) m = s_pix[r][c0];
                    if (s_pix[r][c0+1]   > m) m = s_pix[r][c0+1];
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    d[k*16 +: 16] = 16'(m);
                end
                s_q.push_back('{dat: d, last: (j == SN - 1)});
            end
        end
    endtask

    task automatic send_frame_s(input int early_at, input bit drop_last, input int n_send, input bit gaps);
        int nb, t;
        nb = (early_at >= 0) ? early_at + 1 : n_send;
        for (int j = 0; j < nb; j++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_in_valid = 1'b1;
            s_in_data  = beat_s(j);
            s_in_last  = (j == early_at) || ((j == SN - 1) && !drop_last);
            t = 0;
            @(negedge clk);
            while (!s_in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) check("s_in_timeout", 1, 0);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic drain_s(input string tag);
        int t;
        t = 0;
        while (s_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check(tag, s_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_t1();
        s_pix[0] = '{1, 5, 2, 8, 3, 3, 0, -1};
        s_pix[1] = '{4, 0, 7, 7, -2, -9, 6, -5};
    endtask

    task automatic expect_t1();
        s_q.push_back('{dat: 32'h0008_0005, last: 1'b0});
        s_q.push_back('{dat: 32'h0006_0003, last: 1'b1});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, stalls;
        bit exp_err;
        rst = 1'b1;
        rdy_mode = 0;
        s_in_valid = 0; s_in_last = 0; s_in_data = '0;
        d_in_valid = 0; d_in_last = 0; d_in_data = '0; d_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out_data", s_out_data, 0);
        check("rst_out_last", s_out_last, 0);
        check("rst_frame_err", s_frame_err, 0);
        check("rst_in_ready", s_in_ready, 1);
        check("rst_d_out_valid", d_out_valid, 0);
        @(posedge clk); #1;

        // Test 1: basic frame, always ready.
        load_t1();
        expect_t1();
        send_frame_s(-1, 0, SN, 0);
        drain_s("t1_drain");
        check("t1_frame_err", s_frame_err, 0);

        // Test 2: output held for 5 cycles after the first pooled beat.
        rdy_mode = 1;
        expect_t1();
        fork
            send_frame_s(-1, 0, SN, 0);
            begin
                t = 0;
                @(negedge clk);
                while (!s_out_valid && t < 50) begin
                    t++;
                    @(negedge clk);
                end
                check("t2_first_valid", s_out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    check("t2_in_ready_held", s_in_ready, 0);
                    check("t2_hold_vld", s_out_valid, 1);
                    check("t2_hold_dat", s_out_data, 32'h0008_0005);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                rdy_mode = 0;
            end
        join
        drain_s("t2_drain");

        // Test 3: negative window maxima of -3.
        for (int r = 0; r < SR; r++)
            for (int c = 0; c < SW; c++) s_pix[r][c] = -int'($urandom_range(4, 7));
        for (int w = 0; w < SW / 2; w++) begin
            int p;
            p = $urandom_range(0, 3);
            s_pix[p / 2][2 * w + p % 2] = -3;
        end
        for (int i = 0; i < 2; i++) begin
`ifdef MAXPOOL_RELU_EN
            s_q.push_back('{dat: 32'h0000_0000, last: (i == 1)});
`else
            s_q.push_back('{dat: 32'hFFFD_FFFD, last: (i == 1)});
`endif
        end
        send_frame_s(-1, 0, SN, 0);
        drain_s("t3_drain");

        // Test 4: in_last on beat 3 of 4, then a clean frame.
        load_t1();
        send_frame_s(2, 0, SN, 0);
        @(negedge clk);
        check("t4_frame_err", s_frame_err, 1);
        check("t4_no_output", s_out_valid, 0);
        @(posedge clk); #1;
        expect_t1();
        send_frame_s(-1, 0, SN, 0);
        drain_s("t4_drain");
        check("t4_err_sticky", s_frame_err, 1);

        // Test 5: reset after row 0, then a full frame from a fresh row 0.
        pulse_rst();
        send_frame_s(-1, 0, SB, 0);
        pulse_rst();
        @(negedge clk);
        check("t5_out_valid", s_out_valid, 0);
        check("t5_out_data", s_out_data, 0);
        check("t5_frame_err", s_frame_err, 0);
        @(posedge clk); #1;
        expect_t1();
        send_frame_s(-1, 0, SN, 0);
        drain_s("t5_drain");

        // Randomized frames with random backpressure and occasional framing faults.
        rdy_mode = 2;
        exp_err = 0;
        for (int f = 0; f < 24; f++) begin
            int kind, ea;
            kind = $urandom_range(0, 5);
            for (int r = 0; r < SR; r++)
                for (int c = 0; c < SW; c++) s_pix[r][c] = int'(16'($urandom)) - 32768;
            ea = (kind == 0) ? $urandom_range(0, SN - 2) : -1;
            if (kind <= 1) exp_err = 1;
            model_s(ea);
            send_frame_s(ea, (kind == 1), SN, 1);
        end
        drain_s("rnd_drain");
        check("rnd_frame_err", s_frame_err, exp_err);
        rdy_mode = 0;

        // Test 6: default parameters, 28x28 ramp.
        for (int pr = 0; pr < 14; pr++) begin
            for (int i = 0; i < 7; i++) begin
                logic [31:0] d;
                for (int k = 0; k < OL; k++) d[k*16 +: 16] = 16'((2*pr + 1) * 28 + 2 * (i*2 + k) + 1);
                d_q.push_back('{dat: d, last: (pr == 13 && i == 6)});
            end
        end
        stalls = 0;
        for (int j = 0; j < DN; j++) begin
            d_in_valid = 1'b1;
            d_in_last  = (j == DN - 1);
            for (int k = 0; k < L; k++) d_in_data[k*16 +: 16] = 16'((j / DB) * 28 + (j % DB) * L + k);
            t = 0;
            @(negedge clk);
            while (!d_in_ready && t < 200) begin
                t++;
                stalls++;
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
        t = 0;
        while (d_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("t6_drain", d_q.size(), 0);
        check("t6_stalls", stalls, 0);
        check("t6_out_count", d_outs, 98);
        check("t6_back_to_back", d_gaps, 0);
        check("t6_frame_err", d_frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
